// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch steps, plus ALU-control and immediate-select decoders.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       memready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  if (STATE_W < 4) begin : g_bad_width
    $error("multicycle_ctrl: STATE_W must be at least 4");
  end

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       branch;
  logic       pcupdate;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (memready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTER;
          OP_ITYP:      state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memready) state_d = MEMWB;
      MEMWRITE: if (memready) state_d = FETCH;
      EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
      MEMWB, ALUWB, BEQ:       state_d = FETCH;
      // Encodings beyond the named states recover to FETCH.
      default:  state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = memready;
        pcupdate  = memready;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal = !(op inside {OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_BEQ, OP_JAL});
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB:    regwrite = 1'b1;
      BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite = pcupdate | (branch & zero);

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

endmodule
